// File: rtl/ram_arbiter_if.sv
// Bundle of the per-core cache request buses and the shared RAM port.
interface ram_arbiter_if #(
    parameter int unsigned CPUS   = 2,
    parameter int unsigned WORD_W = 32
);
    // cache side
    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][WORD_W-1:0] iaddr;
    logic [CPUS-1:0][WORD_W-1:0] daddr;
    logic [CPUS-1:0][WORD_W-1:0] dstore;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][WORD_W-1:0] iload;
    logic [CPUS-1:0][WORD_W-1:0] dload;
    // RAM side
    logic                        ramREN;
    logic                        ramWEN;
    logic [WORD_W-1:0]           ramaddr;
    logic [WORD_W-1:0]           ramstore;
    logic [WORD_W-1:0]           ramload;
    logic [1:0]                  ramstate;

    // environment: caches issue requests, RAM returns status/data
    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // arbiter: serves cache requests, drives the RAM port
    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_arbiter.sv
// Multi-core RAM arbiter: one request at a time, data before instruction
// within a core, round-robin priority across cores.
module ram_arbiter #(
    parameter int unsigned CPUS   = 2,
    parameter int unsigned WORD_W = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);
    localparam int unsigned GW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    state_t          r_state,    w_state_nxt;
    logic [GW-1:0]   r_gnt_cpu,  w_gnt_cpu_nxt;
    logic            r_gnt_data, w_gnt_data_nxt;
    logic [GW-1:0]   r_rr_ptr,   w_rr_ptr_nxt;

    logic            w_pick_any;
    logic [GW-1:0]   w_pick_cpu;
    logic            w_pick_data;
    logic [GW-1:0]   w_scan_idx;
    logic            w_req_live;
    logic            w_done;

    // State register: FSM state, latched grant and round-robin pointer
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= IDLE;
            r_gnt_cpu  <= '0;
            r_gnt_data <= 1'b0;
            r_rr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt_cpu  <= w_gnt_cpu_nxt;
            r_gnt_data <= w_gnt_data_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
        end
    end

    // Round-robin scan: first eligible core starting at rr_ptr
    always_comb begin
        w_pick_any  = 1'b0;
        w_pick_cpu  = '0;
        w_pick_data = 1'b0;
        w_scan_idx  = '0;
        for (int unsigned k = 0; k < CPUS; k++) begin
            w_scan_idx = GW'((32'(r_rr_ptr) + k) % CPUS);
            if (!w_pick_any &&
                (bus.iREN[w_scan_idx] | bus.dREN[w_scan_idx] | bus.dWEN[w_scan_idx])) begin
                w_pick_any  = 1'b1;
                w_pick_cpu  = w_scan_idx;
                w_pick_data = bus.dREN[w_scan_idx] | bus.dWEN[w_scan_idx];
            end
        end
    end

    // Granted request still held, and completing when RAM reports ACCESS
    always_comb begin
        w_req_live = r_gnt_data ? (bus.dREN[r_gnt_cpu] | bus.dWEN[r_gnt_cpu])
                                : bus.iREN[r_gnt_cpu];
        w_done     = (r_state == XFER) && w_req_live &&
                     (ramstate_t'(bus.ramstate) == RAM_ACCESS);
    end

    // Next-state: grant in IDLE, complete or abort in XFER (ERROR/BUSY retry)
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_cpu_nxt  = r_gnt_cpu;
        w_gnt_data_nxt = r_gnt_data;
        w_rr_ptr_nxt   = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt    = XFER;
                    w_gnt_cpu_nxt  = w_pick_cpu;
                    w_gnt_data_nxt = w_pick_data;
                end
            end
            XFER: begin
                if (w_done) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = GW'((32'(r_gnt_cpu) + 32'd1) % CPUS);
                end else if (!w_req_live) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs: RAM drive from granted core's live inputs, waits and loads
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iload    = '0;
        bus.dload    = '0;
        if (r_state == XFER) begin
            if (r_gnt_data) begin
                if (bus.dWEN[r_gnt_cpu]) begin
                    bus.ramWEN   = 1'b1;
                    bus.ramaddr  = bus.daddr[r_gnt_cpu];
                    bus.ramstore = bus.dstore[r_gnt_cpu];
                end else if (bus.dREN[r_gnt_cpu]) begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.daddr[r_gnt_cpu];
                end
            end else if (bus.iREN[r_gnt_cpu]) begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr[r_gnt_cpu];
            end
        end
        bus.iwait = bus.iREN;
        bus.dwait = bus.dREN | bus.dWEN;
        if (w_done) begin
            if (r_gnt_data) begin
                bus.dwait[r_gnt_cpu] = 1'b0;
                bus.dload[r_gnt_cpu] = bus.ramload;
            end else begin
                bus.iwait[r_gnt_cpu] = 1'b0;
                bus.iload[r_gnt_cpu] = bus.ramload;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_ram_arbiter;
    localparam int unsigned CPUS = 2;
    localparam int unsigned W    = 32;
    localparam logic [1:0] ST_FREE = 2'd0, ST_BUSY = 2'd1, ST_ACCESS = 2'd2, ST_ERROR = 2'd3;

    logic CLK = 1'b0;
    logic nRST;

    ram_arbiter_if #(.CPUS(CPUS), .WORD_W(W)) bus ();

    ram_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // model: which core/stream is being served, and who has priority
    bit m_busy;
    int m_cpu;
    bit m_data;
    int m_rr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_live();
        if (m_data) return bus.dREN[m_cpu] | bus.dWEN[m_cpu];
        return bus.iREN[m_cpu];
    endfunction

    function automatic bit m_done();
        return nRST && m_busy && m_live() && (bus.ramstate == ST_ACCESS);
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_cpu = 0; m_data = 1'b0; m_rr = 0;
    endtask

    task automatic model_update();
        if (!nRST) begin
            model_reset();
        end else if (!m_busy) begin
            for (int k = 0; k < CPUS; k++) begin
                int c;
                c = (m_rr + k) % CPUS;
                if (!m_busy && (bus.iREN[c] | bus.dREN[c] | bus.dWEN[c])) begin
                    m_busy = 1'b1;
                    m_cpu  = c;
                    m_data = bus.dREN[c] | bus.dWEN[c];
                end
            end
        end else if (m_done()) begin
            m_busy = 1'b0;
            m_rr   = (m_cpu + 1) % CPUS;
        end else if (!m_live()) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic model_check();
        bit done, we, re;
        done = m_done();
        we   = m_busy && m_data && bus.dWEN[m_cpu];
        re   = m_busy && (m_data ? (bus.dREN[m_cpu] && !bus.dWEN[m_cpu]) : bus.iREN[m_cpu]);
        chk("ramWEN", bus.ramWEN, we);
        chk("ramREN", bus.ramREN, re);
        if (we || re)
            chk("ramaddr", bus.ramaddr, m_data ? bus.daddr[m_cpu] : bus.iaddr[m_cpu]);
        if (we)
            chk("ramstore", bus.ramstore, bus.dstore[m_cpu]);
        if (!nRST) begin
            chk("ramaddr_rst", bus.ramaddr, 0);
            chk("ramstore_rst", bus.ramstore, 0);
        end
        for (int c = 0; c < CPUS; c++) begin
            chk("iwait", bus.iwait[c], bus.iREN[c] && !(done && !m_data && m_cpu == c));
            chk("dwait", bus.dwait[c], (bus.dREN[c] | bus.dWEN[c]) && !(done && m_data && m_cpu == c));
            if (done && m_cpu == c) begin
                if (m_data) chk("dload", bus.dload[c], bus.ramload);
                else        chk("iload", bus.iload[c], bus.ramload);
            end
            if (!(m_busy && m_cpu == c)) begin
                chk("iload_zero", bus.iload[c], 0);
                chk("dload_zero", bus.dload[c], 0);
            end
        end
    endtask

    task automatic clear_inputs();
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = ST_FREE;
    endtask

    // inputs are driven at posedge+1, checked at posedge+3
    task automatic check_now();
        #2;
        model_check();
    endtask

    task automatic adv();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic idle_gap();
        clear_inputs();
        check_now();
        adv();
    endtask

    initial begin
        bit exp_dw0 [8];
        bit exp_dw1 [8];

        // reset state, with a request pending
        nRST = 1'b0;
        clear_inputs();
        model_reset();
        bus.iREN[0] = 1'b1;
        bus.iaddr[0] = 32'h55;
        check_now();
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_iload", bus.iload[0], 0);
        chk("rst_iwait", bus.iwait[0], 1);
        adv();
        nRST = 1'b1;
        idle_gap();

        // single fetch, BUSY x2 then ACCESS
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h100; bus.ramstate = ST_BUSY;
        check_now();
        chk("t1_idle_ramREN", bus.ramREN, 0);
        adv();
        for (int i = 0; i < 2; i++) begin
            check_now();
            chk("t1_ramREN", bus.ramREN, 1);
            chk("t1_ramaddr", bus.ramaddr, 32'h100);
            chk("t1_iwait_busy", bus.iwait[0], 1);
            adv();
        end
        bus.ramstate = ST_ACCESS; bus.ramload = 32'hDEADBEEF;
        check_now();
        chk("t1_iwait_done", bus.iwait[0], 0);
        chk("t1_iload", bus.iload[0], 32'hDEADBEEF);
        adv();
        bus.iREN[0] = 1'b0; bus.ramstate = ST_BUSY;
        check_now();
        chk("t1_back_idle", bus.ramREN, 0);
        adv();
        idle_gap();

        // data write beats instruction fetch on the same core
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h300;
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'h12345678;
        bus.ramstate = ST_ACCESS;
        check_now();
        adv();
        check_now();
        chk("t2_ramWEN", bus.ramWEN, 1);
        chk("t2_ramREN", bus.ramREN, 0);
        chk("t2_ramaddr", bus.ramaddr, 32'h200);
        chk("t2_ramstore", bus.ramstore, 32'h12345678);
        chk("t2_dwait", bus.dwait[0], 0);
        chk("t2_iwait_hold", bus.iwait[0], 1);
        adv();
        bus.dWEN[0] = 1'b0;
        check_now();
        chk("t2_gap_iwait", bus.iwait[0], 1);
        chk("t2_gap_ramREN", bus.ramREN, 0);
        adv();
        bus.ramload = 32'h0BADF00D;
        check_now();
        chk("t2_fetch_addr", bus.ramaddr, 32'h300);
        chk("t2_fetch_iwait", bus.iwait[0], 0);
        chk("t2_fetch_iload", bus.iload[0], 32'h0BADF00D);
        adv();
        idle_gap();

        // round-robin: both cores hold dREN, RAM always ACCESS; core1 has priority now
        exp_dw0 = '{1, 1, 1, 0, 1, 1, 1, 0};
        exp_dw1 = '{1, 0, 1, 1, 1, 0, 1, 1};
        bus.dREN = '1; bus.daddr[0] = 32'h10; bus.daddr[1] = 32'h14;
        bus.ramstate = ST_ACCESS;
        for (int i = 0; i < 8; i++) begin
            bus.ramload = 32'hA000 + 32'(i);
            check_now();
            chk("t3_dwait0", bus.dwait[0], exp_dw0[i]);
            chk("t3_dwait1", bus.dwait[1], exp_dw1[i]);
            adv();
        end
        idle_gap();

        // abort: core1 drops dREN after one BUSY cycle
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h400; bus.ramstate = ST_BUSY;
        check_now();
        adv();
        check_now();
        chk("t4_ramREN", bus.ramREN, 1);
        chk("t4_dwait_busy", bus.dwait[1], 1);
        adv();
        bus.dREN[1] = 1'b0; bus.ramstate = ST_ACCESS; bus.ramload = 32'h77;
        check_now();
        chk("t4_no_pulse_dload", bus.dload[1], 0);
        chk("t4_no_enable", bus.ramREN, 0);
        adv();
        bus.dREN = '1; bus.daddr[0] = 32'h500;
        check_now();
        adv();
        check_now();
        chk("t4_rr_kept", bus.ramaddr, 32'h400);
        adv();
        idle_gap();

        // ERROR retry: ERROR, ERROR, ACCESS
        bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h600; bus.ramstate = ST_ERROR;
        check_now();
        adv();
        for (int i = 0; i < 2; i++) begin
            check_now();
            chk("t5_ramREN_err", bus.ramREN, 1);
            chk("t5_iwait_err", bus.iwait[0], 1);
            adv();
        end
        bus.ramstate = ST_ACCESS; bus.ramload = 32'hCAFEF00D;
        check_now();
        chk("t5_ramREN_acc", bus.ramREN, 1);
        chk("t5_iwait_done", bus.iwait[0], 0);
        chk("t5_iload", bus.iload[0], 32'hCAFEF00D);
        adv();
        bus.iREN[0] = 1'b0;
        check_now();
        chk("t5_after", bus.ramREN, 0);
        adv();
        idle_gap();

        // reset mid-XFER
        bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h700; bus.ramstate = ST_BUSY;
        check_now();
        adv();
        check_now();
        chk("t6_ramREN_pre", bus.ramREN, 1);
        #1;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("t6_ramREN_rst", bus.ramREN, 0);
        chk("t6_dwait_rst", bus.dwait[0], 1);
        adv();
        nRST = 1'b1;
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h710; bus.ramstate = ST_ACCESS;
        check_now();
        chk("t6_idle_after", bus.ramREN, 0);
        adv();
        check_now();
        chk("t6_rr_zero", bus.ramaddr, 32'h700);
        chk("t6_dwait0", bus.dwait[0], 0);
        adv();
        idle_gap();

        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!nRST) begin
                nRST = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                nRST = 1'b0;
                model_reset();
            end
            for (int c = 0; c < CPUS; c++) begin
                if (m_busy && m_cpu == c) begin
                    if ($urandom_range(0, 15) == 0) begin
                        bus.iREN[c] = 1'b0; bus.dREN[c] = 1'b0; bus.dWEN[c] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    bus.iREN[c]   = 1'($urandom_range(0, 1));
                    bus.dREN[c]   = 1'($urandom_range(0, 1));
                    bus.dWEN[c]   = 1'($urandom_range(0, 1));
                    bus.iaddr[c]  = $urandom;
                    bus.daddr[c]  = $urandom;
                    bus.dstore[c] = $urandom;
                end
            end
            bus.ramstate = 2'($urandom_range(0, 3));
            bus.ramload  = $urandom;
            check_now();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Multi-core RAM arbiter. It shares the single RAM port between the instruction and data request streams of `CPUS` caches. A two-state FSM grants one request at a time, holds it until RAM reports `ACCESS`, then returns the data and moves priority round-robin across cores. It sits between the per-core cache request buses and the RAM interface, and replaces the single-core pass-through path in the memory-control layer.

## Interface
- `CPUS`, 2: number of requesting cores, 1..8.
- `WORD_W`, 32: address/data width; matches `word_t`.

- `CLK` in 1: clock, rising edge. Clock is `CLK`.
- `nRST` in 1: reset; asynchronous, active-low.
- `iREN` in CPUS: per-core instruction read request.
- `dREN` in CPUS: per-core data read request.
- `dWEN` in CPUS: per-core data write request.
- `iaddr` in CPUS×WORD_W: per-core instruction address.
- `daddr` in CPUS×WORD_W: per-core data address.
- `dstore` in CPUS×WORD_W: per-core write data.
- `iwait` out CPUS: instruction stall; 0 means the transfer completes this cycle.
- `dwait` out CPUS: data stall; 0 means the transfer completes this cycle.
- `iload` out CPUS×WORD_W: instruction read data, valid when `iwait=0`.
- `dload` out CPUS×WORD_W: data read data, valid when `dwait=0` and `dREN` is set.
- `ramREN` out 1: RAM read enable.
- `ramWEN` out 1: RAM write enable.
- `ramaddr` out WORD_W: RAM address.
- `ramstore` out WORD_W: RAM write data.
- `ramload` in WORD_W: RAM read data.
- `ramstate` in 2: RAM status. `FREE`=0, `BUSY`=1, `ACCESS`=2, `ERROR`=3.

## Operation
- **State registers:** `state` (`IDLE`/`XFER`), `gnt_cpu` (clog2(CPUS) bits), `gnt_data` (1 = data request, 0 = instruction), `rr_ptr` (highest-priority core).
- **IDLE:**
  - A core is eligible if any of its `iREN|dREN|dWEN` is set.
  - Pick the first eligible core scanning `rr_ptr, rr_ptr+1, …` mod CPUS.
  - Within that core, data (`dWEN` or `dREN`) beats instruction.
  - Latch `gnt_cpu` and `gnt_data`, then go to XFER.
  - No RAM enables are driven in IDLE.
  - With no eligible core, stay in IDLE.
- **XFER, RAM drive:** combinational from the granted core's live inputs, which the requester must hold stable.
  - Data write: `ramWEN=1`, `ramaddr=daddr`, `ramstore=dstore`.
  - Data read: `ramREN=1`, `ramaddr=daddr`.
  - Instruction: `ramREN=1`, `ramaddr=iaddr`.
  - If both `dWEN` and `dREN` are set, `dWEN` wins.
- **XFER, completion:** when `ramstate==ACCESS`:
  - Drop the granted wait line to 0 for that cycle only.
  - `iload`/`dload` of the granted core = `ramload` (combinational).
  - `rr_ptr <= gnt_cpu+1` mod CPUS.
  - Return to IDLE.
- **XFER, `ERROR`:** treated as `BUSY`; stay in XFER and keep the enables asserted (retry).
- **XFER, abort:** if the granted request bit drops before `ACCESS` (data: `dREN|dWEN` both 0; instruction: `iREN` 0):
  - Return to IDLE next cycle.
  - `rr_ptr` unchanged.
  - No completion pulse.
- **Wait outputs:** combinational.
  - `xwait[c]=1` whenever its request is set and core c / that stream is not completing this cycle.
  - `xwait[c]=0` when not requesting.
- **Load outputs:** `iload`/`dload` for non-granted cores are 0.

## Timing
- **Reset (async):** `state=IDLE`, `rr_ptr=0`, `gnt_cpu=0`, `gnt_data=0`.
- **Outputs during reset:** `ramREN=ramWEN=0`, `ramaddr=ramstore=0`, all `iload`/`dload`=0. Waits follow their combinational rule, so a requesting core sees wait=1.
- **Arbitration latency:** a request seen in IDLE at edge N is driven to RAM from cycle N+1.
- **Completion:** occurs in the first XFER cycle with `ramstate==ACCESS`. If RAM returns `ACCESS` in that first cycle, the transaction takes 2 cycles.
- **Back-to-back:** at least one IDLE cycle separates grants, so per-core throughput is ≤ 1 word per 2 cycles.
- **Simultaneous requests:** ties are resolved only in IDLE. New requests arriving during XFER wait.
- **Reset mid-XFER:** the transaction is abandoned, RAM enables fall immediately, and no completion pulse is issued.
- **Fairness:** no core waits more than CPUS grants after becoming eligible.
- **CPUS=1:** `rr_ptr` stays 0; only data-over-instruction priority applies.

## Test plan
- **Single fetch:** core0 `iREN=1`, `iaddr=0x100`; RAM BUSY×2 then ACCESS, `ramload=0xDEADBEEF` → `ramREN=1`, `ramaddr=0x100` from cycle 1; `iwait[0]=0` and `iload[0]=0xDEADBEEF` in exactly one cycle; then IDLE.
- **Data over instruction:** core0 `iREN=1` and `dWEN=1` (`daddr=0x200`, `dstore=0x12345678`) → the write is served first (`ramWEN=1`, `ramstore=0x12345678`); the fetch is served on the next grant; `iwait[0]` stays 1 throughout the write.
- **Round-robin:** both cores hold `dREN` continuously, RAM always ACCESS → grants alternate core0, core1, core0…; each core completes every 4 cycles.
- **Abort:** core1 `dREN` dropped after 1 BUSY cycle → FSM back to IDLE, `dwait[1]` never 0, `rr_ptr` still points to core1.
- **ERROR retry:** RAM returns ERROR, ERROR, ACCESS → enables held for all three cycles; a single completion on the third.
- **Reset mid-XFER:** `nRST` pulsed low during BUSY → `ramREN=0` immediately, `state=IDLE`, `rr_ptr=0` after release.
